// File: rtl/spi_xip_cache_pkg.sv
// Shared types for the XIP read cache: bus widths, FSM encoding, captured request.
package spi_xip_cache_pkg;

    localparam int unsigned P_ADDR_W = 32;
    localparam int unsigned P_DATA_W = 32;
    localparam int unsigned P_STRB_W = 4;

    typedef enum logic [1:0] {
        XC_IDLE     = 2'd0,
        XC_M_SETUP  = 2'd1,
        XC_M_ACCESS = 2'd2,
        XC_RESP     = 2'd3
    } xc_state_e;

    // Request held stable on the downstream port while a transfer is in flight.
    typedef struct packed {
        logic [P_ADDR_W-1:0] addr;
        logic [2:0]          prot;
        logic                write;
        logic [P_DATA_W-1:0] wdata;
        logic [P_STRB_W-1:0] strb;
        logic                cacheable;
    } xc_req_t;

endpackage

// File: rtl/xip_cache_array.sv
// Direct-mapped valid/tag/data store, one word per line.
//   rd_*    : combinational lookup (hit and data)
//   wr_*    : fill port, sets the entry valid
//   inv_*   : single-entry invalidate; flush clears every valid bit (wins over fill)
module xip_cache_array #(
    parameter int unsigned IDX_W  = 4,
    parameter int unsigned TAG_W  = 26,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [IDX_W-1:0]  rd_idx,
    input  logic [TAG_W-1:0]  rd_tag,
    output logic              rd_hit_c,
    output logic [DATA_W-1:0] rd_data_c,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              inv_en,
    input  logic [IDX_W-1:0]  inv_idx,
    input  logic              flush
);

    localparam int unsigned DEPTH = 32'(1) << IDX_W;

    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [TAG_W-1:0]  tag_q  [DEPTH];
    logic [TAG_W-1:0]  tag_d  [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];

    assign rd_hit_c  = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    assign rd_data_c = data_q[rd_idx];

    // Next-state of the store; flush is applied last so it overrides a same-cycle fill.
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (wr_en) begin
            valid_d[wr_idx] = 1'b1;
            tag_d[wr_idx]   = wr_tag;
            data_d[wr_idx]  = wr_data;
        end
        if (inv_en) begin
            valid_d[inv_idx] = 1'b0;
        end
        if (flush) begin
            valid_d = '0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tag/data need no reset: they are only observed through a valid bit.
    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

endmodule

// File: rtl/spi_xip_cache.sv
// Zero-wait-state read cache in front of the APB-to-SPI flash bridge.
//   s_*      : upstream APB slave port (hits answered in the access cycle)
//   m_*      : downstream APB master port to the SPI bridge (misses, writes, non-flash)
//   flush    : one-cycle pulse invalidating every entry
//   hit_cnt  : cache hits; miss_cnt : cacheable read misses (both wrap)
module spi_xip_cache
    import spi_xip_cache_pkg::*;
#(
    parameter logic [31:0] FLASH_START = 32'h3000_0000,
    parameter logic [31:0] FLASH_END   = 32'h3fff_ffff,
    parameter int unsigned IDX_W       = 4
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [P_ADDR_W-1:0] s_paddr,
    input  logic                s_psel,
    input  logic                s_penable,
    input  logic [2:0]          s_pprot,
    input  logic                s_pwrite,
    input  logic [P_DATA_W-1:0] s_pwdata,
    input  logic [P_STRB_W-1:0] s_pstrb,
    output logic                s_pready,
    output logic [P_DATA_W-1:0] s_prdata,
    output logic                s_pslverr,
    output logic [P_ADDR_W-1:0] m_paddr,
    output logic                m_psel,
    output logic                m_penable,
    output logic [2:0]          m_pprot,
    output logic                m_pwrite,
    output logic [P_DATA_W-1:0] m_pwdata,
    output logic [P_STRB_W-1:0] m_pstrb,
    input  logic                m_pready,
    input  logic [P_DATA_W-1:0] m_prdata,
    input  logic                m_pslverr,
    input  logic                flush,
    output logic [31:0]         hit_cnt,
    output logic [31:0]         miss_cnt
);

    localparam int unsigned TAG_W = P_ADDR_W - IDX_W - 2;

    xc_state_e           state_q, state_d;
    xc_req_t             req_q, req_d;
    logic                m_psel_q, m_psel_d;
    logic                m_penable_q, m_penable_d;
    logic [P_DATA_W-1:0] rdata_q, rdata_d;
    logic                slverr_q, slverr_d;
    logic [31:0]         hit_cnt_q, hit_cnt_d;
    logic [31:0]         miss_cnt_q, miss_cnt_d;

    logic [P_ADDR_W-1:0] s_addr_al;
    logic                s_in_win, s_cacheable, s_access, hit_c;
    logic                rd_hit_c;
    logic [P_DATA_W-1:0] rd_data_c;
    logic                fill_en, inv_en;

    // Upstream decode on the word-aligned address.
    assign s_addr_al   = {s_paddr[P_ADDR_W-1:2], 2'b00};
    assign s_in_win    = (s_addr_al >= FLASH_START) && (s_addr_al <= FLASH_END);
    assign s_cacheable = s_in_win && !s_pwrite;
    assign s_access    = s_psel && s_penable;
    assign hit_c       = (state_q == XC_IDLE) && s_access && s_cacheable && rd_hit_c;

    xip_cache_array #(
        .IDX_W  (IDX_W),
        .TAG_W  (TAG_W),
        .DATA_W (P_DATA_W)
    ) u_array (
        .clk       (clk),
        .resetn    (resetn),
        .rd_idx    (s_paddr[IDX_W+1:2]),
        .rd_tag    (s_paddr[P_ADDR_W-1:IDX_W+2]),
        .rd_hit_c  (rd_hit_c),
        .rd_data_c (rd_data_c),
        .wr_en     (fill_en),
        .wr_idx    (req_q.addr[IDX_W+1:2]),
        .wr_tag    (req_q.addr[P_ADDR_W-1:IDX_W+2]),
        .wr_data   (m_prdata),
        .inv_en    (inv_en),
        .inv_idx   (s_paddr[IDX_W+1:2]),
        .flush     (flush)
    );

    // FSM next-state, downstream request and counters.
    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        m_psel_d    = 1'b0;
        m_penable_d = 1'b0;
        rdata_d     = rdata_q;
        slverr_d    = slverr_q;
        hit_cnt_d   = hit_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        fill_en     = 1'b0;
        inv_en      = 1'b0;
        unique case (state_q)
            XC_IDLE: begin
                if (hit_c) begin
                    hit_cnt_d = hit_cnt_q + 32'd1;
                end else if (s_access) begin
                    req_d.addr      = s_paddr;
                    req_d.prot      = s_pprot;
                    req_d.write     = s_pwrite;
                    req_d.wdata     = s_pwdata;
                    req_d.strb      = s_pstrb;
                    req_d.cacheable = s_cacheable;
                    // A write into the window drops any stale copy of that word.
                    inv_en          = s_pwrite && s_in_win && rd_hit_c;
                    if (s_cacheable) begin
                        miss_cnt_d = miss_cnt_q + 32'd1;
                    end
                    m_psel_d = 1'b1;
                    state_d  = XC_M_SETUP;
                end
            end
            XC_M_SETUP: begin
                m_psel_d    = 1'b1;
                m_penable_d = 1'b1;
                state_d     = XC_M_ACCESS;
            end
            XC_M_ACCESS: begin
                if (m_pready) begin
                    rdata_d  = m_prdata;
                    slverr_d = m_pslverr;
                    fill_en  = req_q.cacheable && !m_pslverr;
                    state_d  = XC_RESP;
                end else begin
                    m_psel_d    = 1'b1;
                    m_penable_d = 1'b1;
                end
            end
            XC_RESP: begin
                state_d = XC_IDLE;
            end
            default: state_d = XC_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= XC_IDLE;
            req_q       <= '0;
            m_psel_q    <= 1'b0;
            m_penable_q <= 1'b0;
            rdata_q     <= '0;
            slverr_q    <= 1'b0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            m_psel_q    <= m_psel_d;
            m_penable_q <= m_penable_d;
            rdata_q     <= rdata_d;
            slverr_q    <= slverr_d;
            hit_cnt_q   <= hit_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
        end
    end

    // Hits respond combinationally; misses respond from registers in RESP.
    assign s_pready  = hit_c || (state_q == XC_RESP);
    assign s_prdata  = hit_c ? rd_data_c : ((state_q == XC_RESP) ? rdata_q : '0);
    assign s_pslverr = (state_q == XC_RESP) && slverr_q;

    assign m_paddr   = req_q.addr;
    assign m_psel    = m_psel_q;
    assign m_penable = m_penable_q;
    assign m_pprot   = req_q.prot;
    assign m_pwrite  = req_q.write;
    assign m_pwdata  = req_q.wdata;
    assign m_pstrb   = req_q.strb;
    assign hit_cnt   = hit_cnt_q;
    assign miss_cnt  = miss_cnt_q;

endmodule

// File: tb/tb_spi_xip_cache.sv
// Directed bench for spi_xip_cache: APB upstream driver, simple downstream slave model.
module tb_spi_xip_cache;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] s_paddr;
    logic        s_psel, s_penable, s_pwrite;
    logic [2:0]  s_pprot;
    logic [31:0] s_pwdata;
    logic [3:0]  s_pstrb;
    logic        s_pready, s_pslverr;
    logic [31:0] s_prdata;
    logic [31:0] m_paddr, m_pwdata, m_prdata;
    logic        m_psel, m_penable, m_pwrite, m_pready, m_pslverr;
    logic [2:0]  m_pprot;
    logic [3:0]  m_pstrb;
    logic        flush;
    logic [31:0] hit_cnt, miss_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // Downstream slave configuration and monitor state.
    int          sl_wait = 0;
    logic [31:0] sl_data = '0;
    logic        sl_err  = 1'b0;
    int          wait_ctr = 0;
    int          xfer_cnt = 0;
    logic [31:0] mon_addr = '0, mon_wdata = '0;
    logic        mon_write = 1'b0;
    logic [3:0]  mon_strb = '0;

    int          exp_hit = 0, exp_miss = 0, exp_xfer = 0;
    logic [31:0] rd;
    logic        er;
    int          cyc;

    always #5 clk = ~clk;

    spi_xip_cache dut (
        .clk       (clk),
        .resetn    (resetn),
        .s_paddr   (s_paddr),
        .s_psel    (s_psel),
        .s_penable (s_penable),
        .s_pprot   (s_pprot),
        .s_pwrite  (s_pwrite),
        .s_pwdata  (s_pwdata),
        .s_pstrb   (s_pstrb),
        .s_pready  (s_pready),
        .s_prdata  (s_prdata),
        .s_pslverr (s_pslverr),
        .m_paddr   (m_paddr),
        .m_psel    (m_psel),
        .m_penable (m_penable),
        .m_pprot   (m_pprot),
        .m_pwrite  (m_pwrite),
        .m_pwdata  (m_pwdata),
        .m_pstrb   (m_pstrb),
        .m_pready  (m_pready),
        .m_prdata  (m_prdata),
        .m_pslverr (m_pslverr),
        .flush     (flush),
        .hit_cnt   (hit_cnt),
        .miss_cnt  (miss_cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Slave: inserts sl_wait wait cycles per access phase, then responds.
    always @(negedge clk) begin
        if (m_psel && m_penable) begin
            if (wait_ctr < sl_wait) begin
                m_pready = 1'b0;
                wait_ctr++;
            end else begin
                m_pready  = 1'b1;
                m_prdata  = sl_data;
                m_pslverr = sl_err;
            end
        end else begin
            m_pready  = 1'b0;
            m_pslverr = 1'b0;
            wait_ctr  = 0;
        end
    end

    // Monitor: one count per downstream setup phase.
    always @(posedge clk) begin
        if (m_psel && !m_penable) begin
            xfer_cnt  <= xfer_cnt + 1;
            mon_addr  <= m_paddr;
            mon_write <= m_pwrite;
            mon_wdata <= m_pwdata;
            mon_strb  <= m_pstrb;
        end
    end

    // Full APB transfer upstream; cycles = wait states seen before s_pready.
    task automatic apb_xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                            input int wt, input logic [31:0] resp, input logic rerr,
                            output logic [31:0] rdata, output logic err, output int cycles);
        int  n;
        bit  done;
        sl_wait = wt;
        sl_data = resp;
        sl_err  = rerr;
        @(negedge clk);
        s_paddr   = addr;
        s_pwrite  = wr;
        s_pwdata  = wdata;
        s_pstrb   = 4'hF;
        s_psel    = 1'b1;
        s_penable = 1'b0;
        @(negedge clk);
        s_penable = 1'b1;
        n    = 0;
        done = 1'b0;
        rdata = '0;
        err   = 1'b0;
        while (!done && n < 64) begin
            #2;
            if (s_pready) begin
                done  = 1'b1;
                rdata = s_prdata;
                err   = s_pslverr;
            end else begin
                @(negedge clk);
                n++;
            end
        end
        cycles = n;
        check_eq("xfer_done", 32'(done), 32'd1);
        @(negedge clk);
        s_psel    = 1'b0;
        s_penable = 1'b0;
        s_pwrite  = 1'b0;
    endtask

    task automatic check_counts(input string tag);
        check_eq({tag, "_hit"},  hit_cnt,  32'(exp_hit));
        check_eq({tag, "_miss"}, miss_cnt, 32'(exp_miss));
        check_eq({tag, "_xfer"}, 32'(xfer_cnt), 32'(exp_xfer));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        resetn = 1'b0; s_paddr = '0; s_psel = 0; s_penable = 0; s_pprot = 3'b010;
        s_pwrite = 0; s_pwdata = '0; s_pstrb = '0; flush = 0;
        m_pready = 0; m_prdata = '0; m_pslverr = 0;
        repeat (3) @(negedge clk);
        #2;
        check_eq("rst_pready", 32'(s_pready), 32'd0);
        check_eq("rst_prdata", s_prdata, 32'd0);
        check_eq("rst_msel", 32'(m_psel), 32'd0);
        check_counts("rst");
        @(negedge clk);
        resetn = 1'b1;

        // Cold miss with 5 wait cycles.
        apb_xfer(32'h3000_0004, 0, '0, 5, 32'hDEAD_BEEF, 0, rd, er, cyc);
        exp_miss++; exp_xfer++;
        check_eq("cold_data", rd, 32'hDEAD_BEEF);
        check_eq("cold_lat", 32'(cyc), 32'd8);
        check_eq("cold_addr", mon_addr, 32'h3000_0004);
        check_eq("cold_err", 32'(er), 32'd0);
        check_counts("cold");

        // Repeat read hits with zero wait states; slave data changed to prove it is not used.
        apb_xfer(32'h3000_0004, 0, '0, 0, 32'h0, 0, rd, er, cyc);
        exp_hit++;
        check_eq("hit_data", rd, 32'hDEAD_BEEF);
        check_eq("hit_lat", 32'(cyc), 32'd0);
        check_counts("hit");

        // Index-1 conflict evicts, then original misses again.
        apb_xfer(32'h3000_0044, 0, '0, 0, 32'h1234_5678, 0, rd, er, cyc);
        exp_miss++; exp_xfer++;
        check_eq("conf_data", rd, 32'h1234_5678);
        check_eq("conf_lat", 32'(cyc), 32'd3);
        apb_xfer(32'h3000_0004, 0, '0, 0, 32'hDEAD_BEEF, 0, rd, er, cyc);
        exp_miss++; exp_xfer++;
        check_eq("evict_data", rd, 32'hDEAD_BEEF);
        check_counts("evict");

        // Non-flash write forwarded unchanged; non-flash reads always forwarded.
        apb_xfer(32'h1000_0000, 1, 32'hA5A5_A5A5, 1, 32'h0, 0, rd, er, cyc);
        exp_xfer++;
        check_eq("wr_addr", mon_addr, 32'h1000_0000);
        check_eq("wr_write", 32'(mon_write), 32'd1);
        check_eq("wr_wdata", mon_wdata, 32'hA5A5_A5A5);
        check_eq("wr_strb", 32'(mon_strb), 32'hF);
        check_counts("wr");
        apb_xfer(32'h1000_0000, 0, '0, 0, 32'h1111_1111, 0, rd, er, cyc);
        exp_xfer++;
        check_eq("nf_rd1", rd, 32'h1111_1111);
        apb_xfer(32'h1000_0000, 0, '0, 0, 32'h2222_2222, 0, rd, er, cyc);
        exp_xfer++;
        check_eq("nf_rd2", rd, 32'h2222_2222);
        check_counts("nf");

        // Window boundaries: just below is uncached, last word is cached.
        apb_xfer(32'h2FFF_FFFC, 0, '0, 0, 32'h3333_3333, 0, rd, er, cyc);
        apb_xfer(32'h2FFF_FFFC, 0, '0, 0, 32'h4444_4444, 0, rd, er, cyc);
        exp_xfer += 2;
        check_eq("below_rd", rd, 32'h4444_4444);
        apb_xfer(32'h3FFF_FFFC, 0, '0, 0, 32'h5555_5555, 0, rd, er, cyc);
        apb_xfer(32'h3FFF_FFFC, 0, '0, 0, 32'h0, 0, rd, er, cyc);
        exp_miss++; exp_xfer++; exp_hit++;
        check_eq("top_hit", rd, 32'h5555_5555);
        check_counts("bound");

        // Write to a cached flash word invalidates it but is still forwarded.
        apb_xfer(32'h3000_0004, 1, 32'h0F0F_0F0F, 0, 32'h0, 0, rd, er, cyc);
        exp_xfer++;
        check_eq("fwr_write", 32'(mon_write), 32'd1);
        apb_xfer(32'h3000_0004, 0, '0, 0, 32'h6666_6666, 0, rd, er, cyc);
        exp_miss++; exp_xfer++;
        check_eq("fwr_reread", rd, 32'h6666_6666);
        check_counts("fwr");

        // Error response: no fill, re-read misses; then fill, hit, flush, miss.
        apb_xfer(32'h3000_0100, 0, '0, 2, 32'hBAD0_BAD0, 1, rd, er, cyc);
        exp_miss++; exp_xfer++;
        check_eq("err_flag", 32'(er), 32'd1);
        check_eq("err_lat", 32'(cyc), 32'd5);
        apb_xfer(32'h3000_0100, 0, '0, 0, 32'h0BAD_F00D, 0, rd, er, cyc);
        exp_miss++; exp_xfer++;
        check_eq("err_refill", rd, 32'h0BAD_F00D);
        check_eq("err_clear", 32'(er), 32'd0);
        apb_xfer(32'h3000_0100, 0, '0, 0, 32'h0, 0, rd, er, cyc);
        exp_hit++;
        check_eq("fill_hit", rd, 32'h0BAD_F00D);
        @(negedge clk); flush = 1'b1;
        @(negedge clk); flush = 1'b0;
        apb_xfer(32'h3000_0100, 0, '0, 0, 32'h7777_7777, 0, rd, er, cyc);
        exp_miss++; exp_xfer++;
        check_eq("flush_miss", rd, 32'h7777_7777);
        check_counts("flush");

        // Re-cache 0x30000004, then reset during the access phase of another miss.
        apb_xfer(32'h3000_0004, 0, '0, 0, 32'h8888_8888, 0, rd, er, cyc);
        apb_xfer(32'h3000_0004, 0, '0, 0, 32'h0, 0, rd, er, cyc);
        check_eq("pre_rst_hit", rd, 32'h8888_8888);
        sl_wait = 20;
        @(negedge clk);
        s_paddr = 32'h3000_0200; s_pwrite = 0; s_psel = 1; s_penable = 0;
        @(negedge clk); s_penable = 1;
        repeat (3) @(negedge clk);
        #2;
        check_eq("mid_msel", 32'(m_psel & m_penable), 32'd1);
        resetn = 1'b0;
        #1;
        check_eq("rst_mid_msel", 32'(m_psel), 32'd0);
        check_eq("rst_mid_pen", 32'(m_penable), 32'd0);
        check_eq("rst_mid_hit", hit_cnt, 32'd0);
        check_eq("rst_mid_miss", miss_cnt, 32'd0);
        @(negedge clk); s_psel = 0; s_penable = 0;
        @(negedge clk); resetn = 1'b1;
        exp_hit = 0; exp_miss = 0; exp_xfer = xfer_cnt;
        apb_xfer(32'h3000_0004, 0, '0, 0, 32'h9999_9999, 0, rd, er, cyc);
        exp_miss++; exp_xfer++;
        check_eq("post_rst_miss", rd, 32'h9999_9999);
        check_counts("post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_xip_cache.md
Name: spi_xip_cache

Overview:
- Read cache for execute-in-place flash fetches, placed directly upstream of the APB-to-SPI flash bridge.
- Accepts APB transfers from the system APB interconnect and answers flash-region read hits with zero wait states.
- Flash-region read misses, and every non-flash or write transfer, are forwarded unchanged as one APB transfer on the downstream port (the SPI bridge). Flash read responses fill a direct-mapped, one-word-per-line array.

Parameters:
FLASH_START, 32'h30000000, first byte address of the cacheable flash window
FLASH_END, 32'h3fffffff, last byte address of the cacheable flash window (inclusive)
IDX_W, 4, log2 of entry count (16 entries of 32 bits)

Ports:
clk  in  1  clock
resetn  in  1  reset
s_paddr  in  P_ADDR_W  upstream APB address
s_psel  in  1  upstream select
s_penable  in  1  upstream enable
s_pprot  in  3  upstream protection, forwarded
s_pwrite  in  1  upstream write
s_pwdata  in  P_DATA_W  upstream write data
s_pstrb  in  P_STRB_W  upstream strobes
s_pready  out  1  upstream ready
s_prdata  out  P_DATA_W  upstream read data
s_pslverr  out  1  upstream error
m_paddr  out  P_ADDR_W  downstream address
m_psel  out  1  downstream select
m_penable  out  1  downstream enable
m_pprot  out  3  downstream protection
m_pwrite  out  1  downstream write
m_pwdata  out  P_DATA_W  downstream write data
m_pstrb  out  P_STRB_W  downstream strobes
m_pready  in  1  downstream ready
m_prdata  in  P_DATA_W  downstream read data
m_pslverr  in  1  downstream error
flush  in  1  one-cycle pulse; invalidate all entries
hit_cnt  out  32  count of cache hits, wraps at 2^32
miss_cnt  out  32  count of flash read misses, wraps at 2^32

Behaviour:
- Reset: clk is the clock; resetn is asynchronous, active-low. On reset: all valid bits 0, state IDLE, every output 0, counters 0.
- Address decode: byte address a = {s_paddr[31:2],2'b00}.
  - Cacheable means FLASH_START <= a <= FLASH_END and s_pwrite = 0.
  - Index = s_paddr[IDX_W+1:2]; tag = s_paddr[31:IDX_W+2].
- FSM states: IDLE, M_SETUP, M_ACCESS, RESP.
- IDLE: the cache acts only when s_psel && s_penable.
  - Cacheable and hit: s_pready = 1 combinationally in that same cycle; s_prdata = entry data; s_pslverr = 0; hit_cnt++; stay in IDLE. Hit latency is 0 wait states.
  - Otherwise: capture paddr, pprot, pwrite, pwdata, pstrb and a cacheable flag into registers; go to M_SETUP. Increment miss_cnt if cacheable.
- M_SETUP: m_psel = 1, m_penable = 0, registered request on the m_ outputs; go to M_ACCESS.
- M_ACCESS: m_psel = 1, m_penable = 1, outputs held stable until m_pready.
  - On m_pready: register m_prdata and m_pslverr; go to RESP.
  - If the flag is cacheable and m_pslverr = 0: write the entry (data, tag, valid = 1).
- RESP: s_pready = 1, s_prdata / s_pslverr from registers; return to IDLE. Miss latency to s_pready is 3 + (downstream wait cycles).
- m_psel and m_penable are 0 in IDLE and RESP. Exactly one downstream transfer occurs per forwarded request.
- Write to an address inside the flash window whose entry tag matches: clear that valid bit when the request is captured. The write is still forwarded.
- Upstream deasserting s_psel while not in IDLE violates the APB protocol. The FSM ignores it and completes the transfer.
- flush: clears all valid bits next edge and does not disturb an in-flight transfer.
  - flush in the same cycle as a fill: flush wins and the entry stays invalid.
  - flush in the same cycle as a hit: the hit still returns the old data.
- The FSM does not accept a new request while it is outside IDLE. Back-to-back hits complete one per cycle.
- Index wrap: conflicting addresses evict each other; there is no replacement choice.
- resetn asserted mid-transfer: m_psel drops immediately and the upstream transfer is abandoned. This matches the downstream bridge, which resets on the same resetn.

Decomposition:
- Shared package/define file: FSM state encodings (XC_IDLE, XC_M_SETUP, XC_M_ACCESS, XC_RESP), plus reuse of P_ADDR_W / P_DATA_W / P_STRB_W from amba_define.v.
- One sub-module, xip_cache_array: valid/tag/data register file.
  - One combinational read port (index in, hit and data out).
  - One write port (fill) and one invalidate port (single-index clear plus flush-all).

Test Plan:
- Cold read of 0x30000004; downstream returns 0xDEADBEEF after 5 wait cycles -> exactly one m_psel transfer with m_paddr = 0x30000004. s_pready arrives 8 cycles after the first access cycle with s_prdata = 0xDEADBEEF. miss_cnt = 1.
- Repeat read of 0x30000004 -> s_pready in the first access cycle, s_prdata = 0xDEADBEEF, m_psel stays 0, hit_cnt = 1.
- Read 0x30000044 (same index 1, IDX_W = 4) returning 0x12345678, then read 0x30000004 -> both are misses, a second downstream transfer occurs, miss_cnt = 3.
- Write 0x10000000 data 0xA5A5A5A5 strb 0xF -> forwarded with m_pwrite = 1 and identical data/strb; no counter change. Read 0x10000000 twice -> forwarded both times.
- Miss with m_pslverr = 1 -> s_pslverr = 1 in RESP and no fill; a re-read of the same address misses again. flush after a valid fill -> the next read of that address misses.
- resetn low during M_ACCESS -> m_psel/m_penable go 0 immediately and counters return to 0. After release, a read of a previously cached address misses.
